mips_load_store_unit: RTL and testbench

Sits between the CPU execute/memory stage and the word-addressed data memory. The data memory has a 1-cycle registered read and a word index address. This block turns byte-addressed MIPS loads and stores into word accesses:
- LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
- Sub-word stores use read-modify-write.
- Loads get sign/zero extension and LWL/LWR merging.
- Misaligned accesses are detected and reported.

---
 rtl/mips_load_store_unit_pkg.sv | 50 +++++
 rtl/mips_load_store_unit_if.sv | 30 +++
 rtl/mips_load_store_unit_byte_lane.sv | 79 +++++++
 rtl/mips_load_store_unit.sv | 111 +++++++++++
 tb/tb_mips_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_load_store_unit_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
//   lsu_op_t      : 4-bit operation code carried on req_op.
//   lsu_state_t   : FSM state encoding, exposed on the debug port.
//   is_misaligned : alignment check from op and byte offset.
//   is_load       : op returns data to the CPU.
//   is_sub_store  : op needs a read-modify-write (SB/SH).
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } lsu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_MERGE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  // Halfwords must sit on even addresses and words on multiples of four.
  // Byte accesses and the LWL/LWR pair exist to handle any offset.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] offset);
    case (op)
      LH, LHU, SH: return offset[0];
      LW, SW:      return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      LB, LBU, LH, LHU, LW, LWL, LWR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_sub_store(input logic [3:0] op);
    return (op == SB) || (op == SH);
  endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// CPU-side request/response bundle of the load/store unit.
//   master : the CPU (drives req_*, receives req_ready and resp_*).
//   slave  : the load/store unit.
// Handshake: a request transfers on a clk edge where req_valid and
// req_ready are both high; the CPU holds req_* stable until then.
// resp_valid is a single-cycle pulse with no back-pressure; resp_rdata
// and resp_addr_err are meaningful only while resp_valid is high.
interface mips_load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       req_rt_old;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_addr_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rt_old,
    input  req_ready, resp_valid, resp_rdata, resp_addr_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rt_old,
    output req_ready, resp_valid, resp_rdata, resp_addr_err
  );
endinterface

// File: rtl/mips_load_store_unit_byte_lane.sv
// Combinational big-endian lane logic (byte offset 0 = bits [31:24]).
//   op, offset : operation and byte offset within the word.
//   mem_word   : word read from data memory.
//   rt_old     : current rt, merged into LWL/LWR results.
//   wdata      : store data (SB uses [7:0], SH uses [15:0]).
//   load_data  : extended/merged load result; 0 for non-load ops.
//   store_word : mem_word with the SB/SH lanes replaced; mem_word otherwise.
module lsu_byte_lane
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] rt_old,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[7:0];
    case (offset)
      2'd0:    byte_sel = mem_word[31:24];
      2'd1:    byte_sel = mem_word[23:16];
      2'd2:    byte_sel = mem_word[15:8];
      default: byte_sel = mem_word[7:0];
    endcase
    half_sel = offset[1] ? mem_word[15:0] : mem_word[31:16];
  end

  always_comb begin
    load_data = 32'h0;
    case (op)
      LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU: load_data = {24'h0, byte_sel};
      LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LHU: load_data = {16'h0, half_sel};
      LW:  load_data = mem_word;
      // LWL fills the upper register bytes from offset k upward.
      LWL: begin
        case (offset)
          2'd0:    load_data = mem_word;
          2'd1:    load_data = {mem_word[23:0], rt_old[7:0]};
          2'd2:    load_data = {mem_word[15:0], rt_old[15:0]};
          default: load_data = {mem_word[7:0],  rt_old[23:0]};
        endcase
      end
      // LWR fills the lower register bytes from offset k downward.
      LWR: begin
        case (offset)
          2'd3:    load_data = mem_word;
          2'd2:    load_data = {rt_old[31:24], mem_word[31:8]};
          2'd1:    load_data = {rt_old[31:16], mem_word[31:16]};
          default: load_data = {rt_old[31:8],  mem_word[31:24]};
        endcase
      end
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_word = mem_word;
    if (op == SB) begin
      case (offset)
        2'd0:    store_word = {wdata[7:0], mem_word[23:0]};
        2'd1:    store_word = {mem_word[31:24], wdata[7:0], mem_word[15:0]};
        2'd2:    store_word = {mem_word[31:16], wdata[7:0], mem_word[7:0]};
        default: store_word = {mem_word[31:8], wdata[7:0]};
      endcase
    end else if (op == SH) begin
      store_word = offset[1] ? {mem_word[31:16], wdata[15:0]}
                             : {wdata[15:0], mem_word[15:0]};
    end
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Byte-addressed MIPS load/store front end for a word-indexed data memory
// with a 1-cycle registered read.
//   clk, reset     : clock, synchronous active-high reset.
//   cpu            : request/response bundle (slave side).
//   data_adress    : word index {2'b00, addr[31:2]} to memory.
//   data_writedata : write word.
//   data_write     : write enable, forced low while reset is high.
//   data_readdata  : read word, valid the cycle after the address.
//   state_dbg      : current FSM state.
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_IDX_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_load_store_unit_if.slave cpu,
  output logic [MEM_IDX_W-1:0] data_adress,
  output logic [31:0]          data_writedata,
  output logic                 data_write,
  input  logic [31:0]          data_readdata,
  output lsu_state_t           state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(S_ISSUE);
  localparam logic [1:0] ST_MERGE = 2'(S_MERGE);
  localparam logic [1:0] ST_RESP  = 2'(S_RESP);

  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rt_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       lane_load;
  logic [31:0]       lane_store;
  logic              req_misaligned;

  lsu_byte_lane u_lane (
    .op         (op_q),
    .offset     (addr_q[1:0]),
    .mem_word   (data_readdata),
    .rt_old     (rt_q),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .store_word (lane_store)
  );

  assign req_misaligned = is_misaligned(cpu.req_op, cpu.req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rt_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu.req_valid) begin
            op_q    <= cpu.req_op;
            addr_q  <= cpu.req_addr;
            wdata_q <= cpu.req_wdata;
            rt_q    <= cpu.req_rt_old;
            rdata_q <= 32'h0;
            err_q   <= req_misaligned;
            // Misaligned requests skip memory entirely.
            state   <= req_misaligned ? ST_RESP : ST_ISSUE;
          end
        end
        // SW and undefined ops finish here; everything else needs the read word.
        ST_ISSUE: state <= (is_load(op_q) || is_sub_store(op_q)) ? ST_MERGE : ST_RESP;
        ST_MERGE: begin
          if (is_load(op_q)) rdata_q <= lane_load;
          state <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the write strobe so a sub-word store cut off mid-flight
  // cannot corrupt memory on the reset edge.
  always_comb begin
    data_write     = 1'b0;
    data_writedata = 32'h0;
    if (!reset) begin
      if (state == ST_ISSUE && op_q == SW) begin
        data_write     = 1'b1;
        data_writedata = wdata_q;
      end else if (state == ST_MERGE && is_sub_store(op_q)) begin
        data_write     = 1'b1;
        data_writedata = lane_store;
      end
    end
  end

  assign data_adress       = MEM_IDX_W'({2'b00, addr_q[ADDR_W-1:2]});
  assign cpu.req_ready     = (state == ST_IDLE);
  assign cpu.resp_valid    = (state == ST_RESP);
  assign cpu.resp_rdata    = rdata_q;
  assign cpu.resp_addr_err = err_q;
  assign state_dbg         = lsu_state_t'(state);

endmodule

// File: tb/tb_mips_load_store_unit.sv
module tb_mips_load_store_unit;
  import mips_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_load_store_unit_if #(.ADDR_W(32)) cpu ();

  logic [31:0] data_adress;
  logic [31:0] data_writedata;
  logic        data_write;
  logic [31:0] data_readdata;
  lsu_state_t  state_dbg;

  mips_load_store_unit #(.ADDR_W(32), .MEM_IDX_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu            (cpu),
    .data_adress    (data_adress),
    .data_writedata (data_writedata),
    .data_write     (data_write),
    .data_readdata  (data_readdata),
    .state_dbg      (state_dbg)
  );

  // Standalone lane instance
  logic [3:0]  bl_op;
  logic [1:0]  bl_off;
  logic [31:0] bl_mem, bl_rt, bl_wd, bl_ld, bl_st;

  lsu_byte_lane u_lane_tb (
    .op         (bl_op),
    .offset     (bl_off),
    .mem_word   (bl_mem),
    .rt_old     (bl_rt),
    .wdata      (bl_wd),
    .load_data  (bl_ld),
    .store_word (bl_st)
  );

  // ---------------- memory model ----------------
  logic [31:0] tb_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_idx] <= pl_data;
    else if (data_write) tb_mem[data_adress[7:0]] <= data_writedata;
    data_readdata <= tb_mem[data_adress[7:0]];
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rt);
    cpu.req_op = op; cpu.req_addr = addr; cpu.req_wdata = wd; cpu.req_rt_old = rt;
    cpu.req_valid = 1'b1;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [3:0]  op;
    logic [1:0]  off;
    logic [31:0] mem, rt, wd, exp_ld, exp_st;
  } lane_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, wd, rt, init;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;   // negedges after E0 until resp_valid
    logic [31:0] exp_mem;
    int          exp_wr;    // data_write pulses
    int          exp_wlat;  // negedge index where the write is seen
  } sys_vec_t;

  lane_vec_t lane_tab [$];
  sys_vec_t  sys_tab  [$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nresp, wr, wlat, first_rdy, acc_c;
    int resp_c [$];
    logic drop;
    logic got, er;
    logic [31:0] rd, widx;

    // ----- lane vectors (big-endian, hand computed) -----
    lane_tab.push_back('{LB,  2'd1, 32'h80FF7F01, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h80FF7F01});
    lane_tab.push_back('{LB,  2'd2, 32'h80FF7F01, 32'h0, 32'h0, 32'h0000007F, 32'h80FF7F01});
    lane_tab.push_back('{LBU, 2'd1, 32'h80FF7F01, 32'h0, 32'h0, 32'h000000FF, 32'h80FF7F01});
    lane_tab.push_back('{LBU, 2'd0, 32'h80FF7F01, 32'h0, 32'h0, 32'h00000080, 32'h80FF7F01});
    lane_tab.push_back('{LH,  2'd0, 32'h80FF7F01, 32'h0, 32'h0, 32'hFFFF80FF, 32'h80FF7F01});
    lane_tab.push_back('{LH,  2'd2, 32'h80FF7F01, 32'h0, 32'h0, 32'h00007F01, 32'h80FF7F01});
    lane_tab.push_back('{LHU, 2'd0, 32'h80FF7F01, 32'h0, 32'h0, 32'h000080FF, 32'h80FF7F01});
    lane_tab.push_back('{LW,  2'd0, 32'h80FF7F01, 32'h0, 32'h0, 32'h80FF7F01, 32'h80FF7F01});
    lane_tab.push_back('{LWL, 2'd0, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h11223344});
    lane_tab.push_back('{LWL, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'h223344DD, 32'h11223344});
    lane_tab.push_back('{LWL, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'h3344CCDD, 32'h11223344});
    lane_tab.push_back('{LWL, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'h44BBCCDD, 32'h11223344});
    lane_tab.push_back('{LWR, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h11223344});
    lane_tab.push_back('{LWR, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'hAA112233, 32'h11223344});
    lane_tab.push_back('{LWR, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'hAABB1122, 32'h11223344});
    lane_tab.push_back('{LWR, 2'd0, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'hAABBCC11, 32'h11223344});
    lane_tab.push_back('{SB,  2'd0, 32'h11223344, 32'h0, 32'h000000AB, 32'h0, 32'hAB223344});
    lane_tab.push_back('{SB,  2'd2, 32'h11223344, 32'h0, 32'h000000AB, 32'h0, 32'h1122AB44});
    lane_tab.push_back('{SB,  2'd3, 32'h11223344, 32'h0, 32'h000000AB, 32'h0, 32'h112233AB});
    lane_tab.push_back('{SH,  2'd0, 32'h11223344, 32'h0, 32'h0000BEEF, 32'h0, 32'hBEEF3344});
    lane_tab.push_back('{SH,  2'd2, 32'h11223344, 32'h0, 32'h0000BEEF, 32'h0, 32'h1122BEEF});

    // ----- system vectors -----
    sys_tab.push_back('{LB,  32'h101, 32'h0, 32'h0, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0, 3, 32'h80FF7F01, 0, 0});
    sys_tab.push_back('{LBU, 32'h101, 32'h0, 32'h0, 32'h80FF7F01, 32'h000000FF, 1'b0, 3, 32'h80FF7F01, 0, 0});
    sys_tab.push_back('{LH,  32'h100, 32'h0, 32'h0, 32'h80FF7F01, 32'hFFFF80FF, 1'b0, 3, 32'h80FF7F01, 0, 0});
    sys_tab.push_back('{LHU, 32'h102, 32'h0, 32'h0, 32'h80FF7F01, 32'h00007F01, 1'b0, 3, 32'h80FF7F01, 0, 0});
    sys_tab.push_back('{SB,  32'h102, 32'h000000AB, 32'h0, 32'h11223344, 32'h0, 1'b0, 3, 32'h1122AB44, 1, 2});
    sys_tab.push_back('{SH,  32'h100, 32'h0000BEEF, 32'h0, 32'h11223344, 32'h0, 1'b0, 3, 32'hBEEF3344, 1, 2});
    sys_tab.push_back('{SW,  32'h100, 32'hCAFEF00D, 32'h0, 32'h11223344, 32'h0, 1'b0, 2, 32'hCAFEF00D, 1, 1});
    sys_tab.push_back('{LWL, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'h223344DD, 1'b0, 3, 32'h11223344, 0, 0});
    sys_tab.push_back('{LWR, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122, 1'b0, 3, 32'h11223344, 0, 0});
    sys_tab.push_back('{LWL, 32'h100, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'h11223344, 1'b0, 3, 32'h11223344, 0, 0});
    sys_tab.push_back('{LWR, 32'h103, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'h11223344, 1'b0, 3, 32'h11223344, 0, 0});
    sys_tab.push_back('{LW,  32'h100, 32'h0, 32'h0, 32'h11223344, 32'h11223344, 1'b0, 3, 32'h11223344, 0, 0});
    sys_tab.push_back('{LW,  32'h102, 32'h0, 32'h0, 32'h11223344, 32'h0, 1'b1, 1, 32'h11223344, 0, 0});
    sys_tab.push_back('{SH,  32'h101, 32'h0000BEEF, 32'h0, 32'h11223344, 32'h0, 1'b1, 1, 32'h11223344, 0, 0});

    // ----- reset -----
    reset = 1'b1;
    cpu.req_valid = 1'b0; cpu.req_op = 4'h0; cpu.req_addr = 32'h0;
    cpu.req_wdata = 32'h0; cpu.req_rt_old = 32'h0;
    bl_op = 4'h0; bl_off = 2'd0; bl_mem = 32'h0; bl_rt = 32'h0; bl_wd = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready",     32'(cpu.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(cpu.resp_valid), 32'h0);
    chk("rst_rdata",     cpu.resp_rdata, 32'h0);
    chk("rst_err",       32'(cpu.resp_addr_err), 32'h0);
    chk("rst_write",     32'(data_write), 32'h0);
    chk("rst_adress",    data_adress, 32'h0);
    chk("rst_wdata",     data_writedata, 32'h0);
    reset = 1'b0;

    // ----- standalone lane table -----
    for (int i = 0; i < lane_tab.size(); i++) begin
      bl_op = lane_tab[i].op; bl_off = lane_tab[i].off; bl_mem = lane_tab[i].mem;
      bl_rt = lane_tab[i].rt; bl_wd = lane_tab[i].wd;
      #1;
      chk($sformatf("lane%0d_load", i),  bl_ld, lane_tab[i].exp_ld);
      chk($sformatf("lane%0d_store", i), bl_st, lane_tab[i].exp_st);
    end

    // ----- system table -----
    for (int i = 0; i < sys_tab.size(); i++) begin
      preload(8'h40, sys_tab[i].init);
      @(negedge clk);
      chk($sformatf("sys%0d_ready", i), 32'(cpu.req_ready), 32'h1);
      drive_req(sys_tab[i].op, sys_tab[i].addr, sys_tab[i].wd, sys_tab[i].rt);
      @(posedge clk);               // E0
      @(negedge clk);
      cpu.req_valid = 1'b0;
      got = 1'b0; lat = 0; nresp = 0; wr = 0; wlat = 0; widx = 32'h0; rd = 32'h0; er = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        if (c > 1) @(negedge clk);
        if (data_write) begin wr++; wlat = c; widx = data_adress; end
        if (cpu.resp_valid) begin
          nresp++;
          if (!got) begin got = 1'b1; lat = c; rd = cpu.resp_rdata; er = cpu.resp_addr_err; end
        end
      end
      chk($sformatf("sys%0d_latency", i), 32'(lat), 32'(sys_tab[i].exp_lat));
      chk($sformatf("sys%0d_npulse", i), 32'(nresp), 32'h1);
      chk($sformatf("sys%0d_rdata", i), rd, sys_tab[i].exp_rd);
      chk($sformatf("sys%0d_err", i), 32'(er), 32'(sys_tab[i].exp_err));
      chk($sformatf("sys%0d_nwrite", i), 32'(wr), 32'(sys_tab[i].exp_wr));
      chk($sformatf("sys%0d_wlat", i), 32'(wlat), 32'(sys_tab[i].exp_wlat));
      if (sys_tab[i].exp_wr != 0) chk($sformatf("sys%0d_widx", i), widx, 32'h40);
      chk($sformatf("sys%0d_mem", i), tb_mem[8'h40], sys_tab[i].exp_mem);
    end

    // ----- reset during MERGE of SB 0x100 -----
    preload(8'h40, 32'h11223344);
    @(negedge clk);
    drive_req(SB, 32'h100, 32'h000000AB, 32'h0);
    @(posedge clk);                 // E0
    @(negedge clk);                 // ISSUE
    cpu.req_valid = 1'b0;
    @(negedge clk);                 // MERGE
    chk("rst_mid_state", 32'(state_dbg), 32'(S_MERGE));
    reset = 1'b1;
    #1;
    chk("rst_mid_write_gated", 32'(data_write), 32'h0);
    @(negedge clk);
    chk("rst_mid_ready", 32'(cpu.req_ready), 32'h1);
    chk("rst_mid_resp", 32'(cpu.resp_valid), 32'h0);
    reset = 1'b0;
    nresp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (cpu.resp_valid) nresp++;
    end
    chk("rst_mid_noresp", 32'(nresp), 32'h0);
    chk("rst_mid_mem", tb_mem[8'h40], 32'h11223344);

    // ----- back-to-back: LW 0x100 then SW 0x104 with valid held -----
    preload(8'h40, 32'h11223344);
    preload(8'h41, 32'h00000000);
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h00000000);
    @(negedge clk);
    drive_req(LW, 32'h100, 32'h0, 32'h0);
    @(posedge clk);                 // E0 of LW
    @(negedge clk);
    drive_req(SW, 32'h104, 32'h5A5AA5A5, 32'h0);
    first_rdy = 0; acc_c = 0; drop = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (drop) begin cpu.req_valid = 1'b0; drop = 1'b0; end
      if (cpu.req_valid && cpu.req_ready) begin
        if (first_rdy == 0) first_rdy = c;
        acc_c = c;
        drop = 1'b1;
      end
      if (cpu.resp_valid) begin
        resp_c.push_back(c);
        if (exp_q.size() == 0) chk("b2b_extra_resp", cpu.resp_rdata, 32'hDEAD0000);
        else chk("b2b_rdata", cpu.resp_rdata, exp_q.pop_front());
      end
    end
    chk("b2b_first_ready", 32'(first_rdy), 32'd4);
    chk("b2b_accept_once", 32'(acc_c), 32'd4);
    chk("b2b_nresp", 32'(resp_c.size()), 32'd2);
    if (resp_c.size() == 2) begin
      chk("b2b_resp0_cycle", 32'(resp_c[0]), 32'd3);
      chk("b2b_resp1_cycle", 32'(resp_c[1]), 32'd6);
    end
    chk("b2b_exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_mem41", tb_mem[8'h41], 32'h5A5AA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
